// File: rtl/core_types_pkg.sv
// Shared core sizing constants and the return-address-stack operation decode.
package core_types_pkg;

  localparam int BTB_TARGET_WIDTH = 12;
  localparam int RAS_DEPTH        = 8;
  localparam int RAS_TARGET_WIDTH = BTB_TARGET_WIDTH;
  localparam int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH);

  typedef enum logic [2:0] {
    RAS_OP_NONE,
    RAS_OP_PUSH,
    RAS_OP_POP,
    RAS_OP_SWAP,
    RAS_OP_RESTORE
  } ras_op_e;

  // A restore squashes everything else; a call and return in the same cycle
  // replace the top entry in place.
  function automatic ras_op_e ras_decode(input logic push, input logic pop,
                                         input logic restore);
    ras_op_e op;
    op = RAS_OP_NONE;
    if (restore)          op = RAS_OP_RESTORE;
    else if (push && pop) op = RAS_OP_SWAP;
    else if (push)        op = RAS_OP_PUSH;
    else if (pop)         op = RAS_OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/ras.sv
// Return address stack: circular flop array with a checkpointable top pointer.
// Optional occupancy tracking is enabled by defining RAS_COUNT_TRACK_EN.
module ras
  import core_types_pkg::*;
#(
  parameter int RAS_DEPTH        = core_types_pkg::RAS_DEPTH,
  parameter int RAS_TARGET_WIDTH = core_types_pkg::RAS_TARGET_WIDTH
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0]   push_target,
  input  logic                          pop_valid,
  output logic [RAS_TARGET_WIDTH-1:0]   pop_target,
  output logic                          pop_target_valid,
  output logic [$clog2(RAS_DEPTH)-1:0]  ras_index,
  input  logic                          restore_valid,
`ifdef RAS_COUNT_TRACK_EN
  input  logic [$clog2(RAS_DEPTH):0]    restore_count,
  output logic [$clog2(RAS_DEPTH):0]    ras_count,
`endif
  input  logic [$clog2(RAS_DEPTH)-1:0]  restore_index
);

  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [RAS_TARGET_WIDTH-1:0] entry [RAS_DEPTH];
  logic [PTR_W-1:0]            ptr;
  logic [PTR_W-1:0]            ptr_inc;
  logic [PTR_W-1:0]            ptr_dec;
  logic [PTR_W-1:0]            ptr_nxt;
  logic [PTR_W-1:0]            wr_idx;
  logic                        wr_en;
  ras_op_e                     op;

  assign op      = ras_decode(push_valid, pop_valid, restore_valid);
  assign ptr_inc = ptr + 1'b1;
  assign ptr_dec = ptr - 1'b1;

  always_comb begin
    ptr_nxt = ptr;
    wr_en   = 1'b0;
    wr_idx  = ptr;
    case (op)
      RAS_OP_RESTORE: ptr_nxt = restore_index;
      RAS_OP_SWAP: begin
        wr_en  = 1'b1;
        wr_idx = ptr;
      end
      RAS_OP_PUSH: begin
        ptr_nxt = ptr_inc;
        wr_en   = 1'b1;
        wr_idx  = ptr_inc;
      end
      RAS_OP_POP:  ptr_nxt = ptr_dec;
      default:     ptr_nxt = ptr;
    endcase
  end

  // Pointer and entry state; wrap-around is silent in both directions.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) entry[i] <= '0;
    end else begin
      ptr <= ptr_nxt;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        if (wr_en && (wr_idx == i[PTR_W-1:0])) entry[i] <= push_target;
      end
    end
  end

  assign pop_target = entry[ptr];
  assign ras_index  = ptr;

`ifdef RAS_COUNT_TRACK_EN
  localparam logic [PTR_W:0] COUNT_MAX = RAS_DEPTH[PTR_W:0];

  logic [PTR_W:0] count;
  logic [PTR_W:0] count_nxt;

  always_comb begin
    count_nxt = count;
    case (op)
      RAS_OP_RESTORE: count_nxt = restore_count;
      RAS_OP_PUSH:    if (count != COUNT_MAX) count_nxt = count + 1'b1;
      RAS_OP_POP:     if (count != '0)        count_nxt = count - 1'b1;
      default:        count_nxt = count;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) count <= '0;
    else       count <= count_nxt;
  end

  assign ras_count        = count;
  assign pop_target_valid = (count != '0);
`else
  assign pop_target_valid = 1'b1;
`endif

endmodule

// File: tb/tb_ras.sv
// Self-checking bench for ras: directed vector table, hand sequences and a
// randomized run against an arithmetic stack model.
module tb_ras;
  import core_types_pkg::*;

  localparam int D  = RAS_DEPTH;
  localparam int W  = RAS_TARGET_WIDTH;
  localparam int LW = LOG_RAS_DEPTH;

  logic          CLK;
  logic          nRST;
  logic          push_valid;
  logic [W-1:0]  push_target;
  logic          pop_valid;
  logic [W-1:0]  pop_target;
  logic          pop_target_valid;
  logic [LW-1:0] ras_index;
  logic          restore_valid;
  logic [LW-1:0] restore_index;
`ifdef RAS_COUNT_TRACK_EN
  logic [LW:0]   restore_count;
  logic [LW:0]   ras_count;
`endif

  int checks = 0;
  int errors = 0;

  ras dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .push_valid       (push_valid),
    .push_target      (push_target),
    .pop_valid        (pop_valid),
    .pop_target       (pop_target),
    .pop_target_valid (pop_target_valid),
    .ras_index        (ras_index),
    .restore_valid    (restore_valid),
`ifdef RAS_COUNT_TRACK_EN
    .restore_count    (restore_count),
    .ras_count        (ras_count),
`endif
    .restore_index    (restore_index)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic          push;
    logic          pop;
    logic          rest;
    logic [W-1:0]  tgt;
    logic [LW-1:0] ridx;
    logic [W-1:0]  exp_top;
    logic [LW-1:0] exp_idx;
    string         name;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a plain array plus integer top pointer and occupancy.
  logic [W-1:0] m_mem [D];
  int           m_ptr;
  int           m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [W-1:0] t, input logic q,
                       input logic r, input logic [LW-1:0] ri, input int rc);
    push_valid    = p;
    push_target   = t;
    pop_valid     = q;
    restore_valid = r;
    restore_index = ri;
`ifdef RAS_COUNT_TRACK_EN
    restore_count = rc[LW:0];
`endif
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  task automatic model_step(input logic p, input logic [W-1:0] t, input logic q,
                            input logic r, input int ri, input int rc);
    if (r) begin
      m_ptr = ri;
      m_cnt = rc;
    end else if (p && q) begin
      m_mem[m_ptr] = t;
    end else if (p) begin
      m_ptr = (m_ptr + 1) % D;
      m_mem[m_ptr] = t;
      m_cnt = (m_cnt < D) ? m_cnt + 1 : D;
    end else if (q) begin
      m_ptr = (m_ptr + D - 1) % D;
      m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
    end
  endtask

  function automatic logic model_valid();
`ifdef RAS_COUNT_TRACK_EN
    return m_cnt != 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 0);
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
  endtask

  task automatic add(input logic p, input logic [W-1:0] t, input logic q, input logic r,
                     input logic [LW-1:0] ri, input logic [W-1:0] et,
                     input logic [LW-1:0] ei, input string nm);
    vec_t v;
    v.push = p; v.pop = q; v.rest = r; v.tgt = t; v.ridx = ri;
    v.exp_top = et; v.exp_idx = ei; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    int unsigned rnd;
    logic          rp, rq, rr;
    logic [W-1:0]  rt;
    int            ri, rc;

    nRST = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 0);

    // Expected top/index are the values seen before the edge that applies the op.
    add(1, 12'h111, 0, 0, 0, 12'h000, 0, "push111");
    add(1, 12'h222, 0, 0, 0, 12'h111, 1, "push222");
    add(1, 12'h333, 0, 0, 0, 12'h222, 2, "push333");
    add(0, 12'h000, 1, 0, 0, 12'h333, 3, "pop333");
    add(0, 12'h000, 1, 0, 0, 12'h222, 2, "pop222");
    add(0, 12'h000, 1, 0, 0, 12'h111, 1, "pop111");
    add(0, 12'h000, 0, 0, 0, 12'h000, 0, "empty_top");
    add(1, 12'hAAA, 0, 0, 0, 12'h000, 0, "pushAAA");
    add(1, 12'hBBB, 1, 0, 0, 12'hAAA, 1, "swap_old_top");
    add(0, 12'h000, 0, 0, 0, 12'hBBB, 1, "swap_new_top");
    add(1, 12'h444, 0, 0, 0, 12'hBBB, 1, "push444");
    add(0, 12'h000, 0, 0, 0, 12'h444, 2, "checkpoint2");
    add(1, 12'h555, 0, 0, 0, 12'h444, 2, "push555");
    add(1, 12'h666, 0, 0, 0, 12'h555, 3, "push666");
    add(0, 12'h000, 1, 0, 0, 12'h666, 4, "pop666");
    add(1, 12'h777, 0, 1, 2, 12'h555, 3, "restore_push");
    add(0, 12'h000, 0, 0, 0, 12'h444, 2, "restored2");
    add(0, 12'h000, 0, 1, 4, 12'h444, 2, "restore4");
    add(0, 12'h000, 0, 0, 0, 12'h666, 4, "entry4_kept");
    add(0, 12'h000, 1, 1, 3, 12'h666, 4, "restore_pop");
    add(0, 12'h000, 0, 0, 0, 12'h555, 3, "entry3_kept");

    do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 0);
    chk("reset_top", pop_target, 0);
    chk("reset_idx", ras_index, 0);
`ifdef RAS_COUNT_TRACK_EN
    chk("reset_valid", pop_target_valid, 0);
    chk("reset_count", ras_count, 0);
`else
    chk("reset_valid", pop_target_valid, 1);
`endif

    foreach (vecs[k]) begin
      drive(vecs[k].push, vecs[k].tgt, vecs[k].pop, vecs[k].rest, vecs[k].ridx, 0);
      chk({vecs[k].name, "_top"}, pop_target, vecs[k].exp_top);
      chk({vecs[k].name, "_idx"}, ras_index, vecs[k].exp_idx);
      tick();
    end

    // Wrap: nine pushes into depth eight, then nine pops.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, W'(k), 1'b0, 1'b0, '0, 0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, 0);
    chk("wrap_idx", ras_index, 1);
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, '0, 1'b1, 1'b0, '0, 0);
      chk($sformatf("wrap_pop%0d", k), pop_target, (k < 8) ? 9 - k : 9);
      tick();
    end

`ifdef RAS_COUNT_TRACK_EN
    do_reset();
    drive(1'b0, '0, 1'b1, 1'b0, '0, 0);
    chk("cnt_pop_empty_valid", pop_target_valid, 0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 0);
    chk("cnt_after_pop", ras_count, 0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, W'(k + 32), 1'b0, 1'b0, '0, 0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, 0);
    chk("cnt_full", ras_count, 8);
    chk("cnt_full_valid", pop_target_valid, 1);
    drive(1'b1, 12'h099, 1'b0, 1'b0, '0, 0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 0);
    chk("cnt_sat", ras_count, 8);
`endif

    // Asynchronous reset with a push pending at ptr=5.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, W'(k + 16), 1'b0, 1'b0, '0, 0);
      tick();
    end
    drive(1'b1, 12'hFFF, 1'b0, 1'b0, '0, 0);
    chk("pre_rst_idx", ras_index, 5);
    chk("pre_rst_top", pop_target, 20);
    nRST = 1'b0;
    #1;
    chk("async_rst_idx", ras_index, 0);
    chk("async_rst_top", pop_target, 0);
    @(posedge CLK);
    #1;
    chk("rst_hold_idx", ras_index, 0);
    @(negedge CLK);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 0);
    nRST = 1'b1;
    for (int k = 0; k < D; k++) begin
      drive(1'b0, '0, 1'b0, 1'b1, LW'(k), 0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, '0, 0);
      chk($sformatf("rst_entry%0d", k), pop_target, 0);
      chk($sformatf("rst_walk_idx%0d", k), ras_index, k);
    end

    // Randomized run against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom;
      rp  = rnd[0];
      rq  = rnd[1];
      rr  = (rnd[6:2] == 0);
      rt  = W'($urandom);
      ri  = $urandom_range(D - 1, 0);
      rc  = $urandom_range(D, 0);
      drive(rp, rt, rq, rr, LW'(ri), rc);
      chk("rnd_top", pop_target, m_mem[m_ptr]);
      chk("rnd_idx", ras_index, m_ptr);
      chk("rnd_valid", pop_target_valid, model_valid());
`ifdef RAS_COUNT_TRACK_EN
      chk("rnd_count", ras_count, m_cnt);
`endif
      tick();
      model_step(rp, rt, rq, rr, ri, rc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
